// File: rtl/signature_test_controller.sv
// signature_test_controller: on-chip self-test sequencer for the 8-bit CUT.
// Clears the CUT, streams LFSR vectors into it, compacts its outputs into a
// 16-bit MISR and reports the final signature with a held done level.
module signature_test_controller #(
  parameter int NUM_VECTORS  = 256,
  parameter int CLEAR_CYCLES = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        start,
  input  logic [7:0]  seed,
  output logic        dut_clear,
  output logic [7:0]  dut_input,
  input  logic [7:0]  dut_output,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    FLUSH,
    DONE
  } state_t;

  // Terminal counts; counters start at zero so the last cycle is count-1.
  localparam logic [15:0] CLEAR_LAST = 16'(CLEAR_CYCLES - 1);
  localparam logic [15:0] VEC_LAST   = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [7:0]  lfsr;
  logic [7:0]  lfsr_next;
  logic [15:0] misr_next;
  logic [15:0] phase_cnt;
  logic [15:0] vec_cnt;

  // Galois right-shift LFSR step and MISR compaction of the current CUT output.
  assign lfsr_next = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
  assign misr_next = ({signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000))
                     ^ {8'h00, dut_output};

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      lfsr      <= 8'h01;
      signature <= 16'h0000;
      phase_cnt <= 16'h0000;
      vec_cnt   <= 16'h0000;
      dut_clear <= 1'b0;
      dut_input <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            lfsr      <= (seed == 8'h00) ? 8'h01 : seed;
            signature <= 16'h0000;
            phase_cnt <= 16'h0000;
            vec_cnt   <= 16'h0000;
            dut_clear <= 1'b1;
            dut_input <= 8'h00;
            busy      <= 1'b1;
            done      <= 1'b0;
            state     <= CLEAR;
          end
        end

        CLEAR: begin
          if (phase_cnt == CLEAR_LAST) begin
            dut_clear <= 1'b0;
            dut_input <= lfsr;
            lfsr      <= lfsr_next;
            vec_cnt   <= 16'h0000;
            state     <= RUN;
          end else begin
            phase_cnt <= phase_cnt + 16'h0001;
          end
        end

        RUN: begin
          signature <= misr_next;
          if (vec_cnt == VEC_LAST) begin
            dut_input <= 8'h00;
            phase_cnt <= 16'h0000;
            if (FLUSH_CYCLES == 0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= FLUSH;
            end
          end else begin
            vec_cnt   <= vec_cnt + 16'h0001;
            dut_input <= lfsr;
            lfsr      <= lfsr_next;
          end
        end

        FLUSH: begin
          signature <= misr_next;
          if (phase_cnt == FLUSH_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            phase_cnt <= phase_cnt + 16'h0001;
          end
        end

        default: begin
          state     <= IDLE;
          dut_clear <= 1'b0;
          dut_input <= 8'h00;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signature_test_controller.sv
// tb_signature_test_controller: scoreboard bench for three controller
// configurations sharing clock, reset and seed, each with its own start.
module tb_signature_test_controller;

  logic        clk;
  logic        clear_n;
  logic [7:0]  seed;
  logic        zero_cut;
  logic        start_v     [3];
  logic        dut_clear_v [3];
  logic [7:0]  dut_input_v [3];
  logic [7:0]  dut_output_v[3];
  logic        busy_v      [3];
  logic        done_v      [3];
  logic [15:0] sig_v       [3];

  int nv_t[3] = '{1, 256, 5};
  int cc_t[3] = '{2, 2, 2};
  int fc_t[3] = '{1, 1, 0};

  int vectors     = 0;
  int miscompares = 0;
  int sel         = 0;
  logic [31:0] exp_q[$];
  logic [15:0] sig_clean;
  logic [15:0] sig_tmp;

  signature_test_controller #(.NUM_VECTORS(1), .CLEAR_CYCLES(2), .FLUSH_CYCLES(1)) u_a (
    .clk(clk), .clear_n(clear_n), .start(start_v[0]), .seed(seed),
    .dut_clear(dut_clear_v[0]), .dut_input(dut_input_v[0]), .dut_output(dut_output_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .signature(sig_v[0]));

  signature_test_controller u_b (
    .clk(clk), .clear_n(clear_n), .start(start_v[1]), .seed(seed),
    .dut_clear(dut_clear_v[1]), .dut_input(dut_input_v[1]), .dut_output(dut_output_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .signature(sig_v[1]));

  signature_test_controller #(.NUM_VECTORS(5), .CLEAR_CYCLES(2), .FLUSH_CYCLES(0)) u_c (
    .clk(clk), .clear_n(clear_n), .start(start_v[2]), .seed(seed),
    .dut_clear(dut_clear_v[2]), .dut_input(dut_input_v[2]), .dut_output(dut_output_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .signature(sig_v[2]));

  // Pass-through CUT, or a CUT whose output is stuck at zero.
  assign dut_output_v[0] = zero_cut ? 8'h00 : dut_input_v[0];
  assign dut_output_v[1] = zero_cut ? 8'h00 : dut_input_v[1];
  assign dut_output_v[2] = zero_cut ? 8'h00 : dut_input_v[2];

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    logic [7:0] r;
    r = l >> 1;
    if (l[0]) r = r ^ 8'hB8;
    return r;
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [7:0] d);
    logic [15:0] r;
    r = m << 1;
    if (m[15]) r = r ^ 16'h1021;
    return r ^ {8'h00, d};
  endfunction

  function automatic logic [31:0] obs_vec(input int i);
    return {5'd0, dut_clear_v[i], busy_v[i], done_v[i], dut_input_v[i], sig_v[i]};
  endfunction

  function automatic logic [31:0] pack_exp(input logic c, input logic b, input logic d,
                                           input logic [7:0] v, input logic [15:0] s);
    return {5'd0, c, b, d, v, s};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  // Scoreboard consumer: one expected output word per cycle of the active run.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check_output("cycle", obs_vec(sel), exp_q.pop_front());
    end
  end

  // Pushes the expected per-cycle trace, pulses start and waits for the trace
  // to drain; optionally pokes start mid-run or asserts reset mid-run.
  task automatic apply_stimulus(input int inst, input logic [7:0] seed_val,
                                input int pulse_at, input int reset_at,
                                output logic [15:0] final_sig);
    logic [7:0]  l;
    logic [15:0] m;
    int          cyc;
    l = (seed_val == 8'h00) ? 8'h01 : seed_val;
    m = 16'h0000;
    for (int k = 0; k < cc_t[inst]; k++) exp_q.push_back(pack_exp(1'b1, 1'b1, 1'b0, 8'h00, m));
    for (int j = 0; j < nv_t[inst]; j++) begin
      exp_q.push_back(pack_exp(1'b0, 1'b1, 1'b0, l, m));
      m = misr_step(m, zero_cut ? 8'h00 : l);
      l = lfsr_step(l);
    end
    for (int f = 0; f < fc_t[inst]; f++) begin
      exp_q.push_back(pack_exp(1'b0, 1'b1, 1'b0, 8'h00, m));
      m = misr_step(m, 8'h00);
    end
    exp_q.push_back(pack_exp(1'b0, 1'b0, 1'b1, 8'h00, m));
    exp_q.push_back(pack_exp(1'b0, 1'b0, 1'b1, 8'h00, m));
    final_sig = m;
    sel = inst;
    seed = seed_val;
    start_v[inst] = 1'b1;
    @(negedge clk); #1;
    start_v[inst] = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 2000) begin
      @(negedge clk); #1;
      cyc++;
      start_v[inst] = (cyc == pulse_at);
      if (cyc == reset_at) begin
        exp_q.delete();
        clear_n = 1'b0;
        #1;
        check_output("async_reset_inst", obs_vec(inst), 32'h0);
        check_output("async_reset_a", obs_vec(0), 32'h0);
        @(negedge clk); #1;
        clear_n = 1'b1;
        return;
      end
    end
    start_v[inst] = 1'b0;
    check_output("drain_timeout", 32'(exp_q.size()), 32'h0);
    check_output("final_sig", {16'h0, sig_v[inst]}, {16'h0, final_sig});
  endtask

  initial begin
    clear_n  = 1'b0;
    seed     = 8'h00;
    zero_cut = 1'b0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_output("reset_state", obs_vec(i), 32'h0);
    check_output("reset_lfsr", {24'h0, u_c.lfsr}, 32'h01);
    #1 clear_n = 1'b1;
    @(negedge clk); #1;

    apply_stimulus(0, 8'h01, -1, -1, sig_tmp);
    check_output("small_seed01", {16'h0, sig_v[0]}, 32'h0002);
    apply_stimulus(0, 8'h00, -1, -1, sig_tmp);
    check_output("small_seed00", {16'h0, sig_v[0]}, 32'h0002);

    apply_stimulus(2, 8'h01, -1, -1, sig_tmp);
    check_output("five_vec_sig", {16'h0, sig_v[2]}, 32'h04EB);
    check_output("five_vec_lfsr", {24'h0, u_c.lfsr}, 32'hB3);

    zero_cut = 1'b1;
    apply_stimulus(1, 8'hA5, -1, -1, sig_tmp);
    check_output("zero_cut_sig", {16'h0, sig_v[1]}, 32'h0000);
    zero_cut = 1'b0;

    apply_stimulus(1, 8'h5A, -1, -1, sig_clean);
    apply_stimulus(1, 8'h5A, 2 + 9, -1, sig_tmp);
    check_output("mid_start_sig", {16'h0, sig_v[1]}, {16'h0, sig_clean});

    apply_stimulus(1, 8'h5A, -1, 2 + 20, sig_tmp);
    apply_stimulus(1, 8'h5A, -1, -1, sig_tmp);
    check_output("after_reset_sig", {16'h0, sig_v[1]}, {16'h0, sig_clean});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
